// File: rtl/factor_search_ctrl_if.sv
// factor_search_ctrl_if
// Divider bus between the factor search controller (master) and the shared
// serial divider datapath (slave). The controller issues numerator/divisor
// with a one-cycle div_start and waits for a one-cycle div_done carrying the
// quotient and the remainder-is-zero flag.

interface factor_search_ctrl_if #(
   parameter int N_W = 32,
   parameter int D_W = 16
);
   logic           div_start;
   logic [N_W-1:0] div_n;
   logic [D_W-1:0] div_d;
   logic           div_done;
   logic [N_W-1:0] div_q;
   logic           div_is_factor;

   modport master (
      output div_start, div_n, div_d,
      input  div_done, div_q, div_is_factor
   );

   modport slave (
      input  div_start, div_n, div_d,
      output div_done, div_q, div_is_factor
   );
endinterface

// File: rtl/factor_search_ctrl.sv
// factor_search_ctrl
// Trial-division sequencer for the smallest nontrivial factor of a product.
// Drives one shared serial divider with a start/done handshake, stepping the
// candidate divisor from D_START upward until a factor is found or the
// candidate range is exhausted.
//
// Optional build macro: FACTOR_SQRT_BOUND_EN
//   defined     - search stops once (d+1)^2 > product, so found=0 means prime.
//   not defined - search stops once d+1 > MAX_D; no multiplier is built.
// In both builds the search also stops if d+1 overflows D_W bits.

module factor_search_ctrl #(
   parameter int             N_W     = 32,
   parameter int             D_W     = 16,
   parameter logic [D_W-1:0] D_START = D_W'(2),
   parameter logic [D_W-1:0] MAX_D   = {D_W{1'b1}}
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N_W-1:0] product,
   output logic           busy,
   output logic           done,
   output logic           found,
   output logic [D_W-1:0] factor_a,
   output logic [N_W-1:0] factor_b,
   output logic [D_W-1:0] cand_count,
   factor_search_ctrl_if.master div
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Width wide enough for both the squared candidate and the product.
   localparam int CMP_W = (2 * D_W > N_W) ? 2 * D_W : N_W;

   state_t         state_r;
   logic [N_W-1:0] n_r;
   logic [D_W-1:0] d_r;
   logic           div_start_r;

   logic [D_W:0]   d_next_s;
   logic           stop_s;
`ifdef FACTOR_SQRT_BOUND_EN
   logic [2*D_W-1:0] sq_s;
`endif

   // Latched product and current candidate are driven straight from registers.
   assign div.div_start = div_start_r;
   assign div.div_n     = n_r;
   assign div.div_d     = d_r;

   // Next candidate and the end-of-range decision after a non-factor result.
   always_comb begin
      d_next_s = {1'b0, d_r} + {{D_W{1'b0}}, 1'b1};
`ifdef FACTOR_SQRT_BOUND_EN
      sq_s   = {{D_W{1'b0}}, d_next_s[D_W-1:0]} * {{D_W{1'b0}}, d_next_s[D_W-1:0]};
      stop_s = d_next_s[D_W] | (CMP_W'(sq_s) > CMP_W'(n_r));
`else
      stop_s = d_next_s[D_W] | (d_next_s[D_W-1:0] > MAX_D);
`endif
   end

   // Search FSM with registered status, result and divider-request outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         n_r         <= {N_W{1'b0}};
         d_r         <= {D_W{1'b0}};
         div_start_r <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         factor_a    <= {D_W{1'b0}};
         factor_b    <= {N_W{1'b0}};
         cand_count  <= {D_W{1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  n_r        <= product;
                  d_r        <= D_START;
                  cand_count <= {D_W{1'b0}};
                  found      <= 1'b0;
                  factor_a   <= {D_W{1'b0}};
                  factor_b   <= {N_W{1'b0}};
                  busy       <= 1'b1;
                  // 0..3 have no nontrivial factor: report at once.
                  if (product < N_W'(4)) begin
                     state_r <= FIN;
                     done    <= 1'b1;
                  end else begin
                     state_r     <= ISSUE;
                     div_start_r <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               div_start_r <= 1'b0;
               cand_count  <= cand_count + D_W'(1);
               state_r     <= WAIT;
            end
            WAIT: begin
               if (div.div_done) begin
                  if (div.div_is_factor) begin
                     factor_a <= d_r;
                     factor_b <= div.div_q;
                     found    <= 1'b1;
                     state_r  <= FIN;
                     done     <= 1'b1;
                  end else if (stop_s) begin
                     state_r <= FIN;
                     done    <= 1'b1;
                  end else begin
                     d_r         <= d_next_s[D_W-1:0];
                     state_r     <= ISSUE;
                     div_start_r <= 1'b1;
                  end
               end
            end
            FIN: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy        <= 1'b0;
               div_start_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_factor_search_ctrl.sv
// tb_factor_search_ctrl
// Self-checking bench: fixed-latency divider model, behavioural trial-division
// reference, and one negedge compare process on div_start and done cycles.

module tb_factor_search_ctrl;

   localparam int          LAT        = 3;
   localparam logic [15:0] TB_D_START = 16'd2;
   localparam logic [15:0] TB_MAX_D   = 16'd5;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] product;
   logic        busy, done, found;
   logic [15:0] factor_a, cand_count;
   logic [31:0] factor_b;

   factor_search_ctrl_if #(.N_W(32), .D_W(16)) dbus ();

   factor_search_ctrl #(
      .N_W(32), .D_W(16), .D_START(TB_D_START), .MAX_D(TB_MAX_D)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .product(product),
      .busy(busy), .done(done), .found(found), .factor_a(factor_a),
      .factor_b(factor_b), .cand_count(cand_count), .div(dbus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference expectations for the request in flight
   int          exp_cands[$];
   int          idx = 0;
   bit          exp_active = 1'b0;
   bit          got_done = 1'b0;
   logic [31:0] cur_p = 32'd0;
   bit          exp_found;
   logic [15:0] exp_a, exp_cnt;
   logic [31:0] exp_b;
   int          req_d;

   // divider model state
   int          dv_cnt = 0;
   logic [31:0] dv_n;
   logic [15:0] dv_d;

   // Plain trial division from the candidate rules.
   task automatic model(input logic [31:0] p);
      longint d, pn;
      pn = longint'(p);
      exp_cands.delete();
      exp_found = 1'b0; exp_a = 16'd0; exp_b = 32'd0;
      if (pn >= 4) begin
         d = longint'(TB_D_START);
         forever begin
            exp_cands.push_back(int'(d));
            if (pn % d == 0) begin
               exp_found = 1'b1; exp_a = 16'(d); exp_b = 32'(pn / d);
               break;
            end
`ifdef FACTOR_SQRT_BOUND_EN
            if ((d + 1) * (d + 1) > pn) break;
`else
            if (d + 1 > longint'(TB_MAX_D)) break;
`endif
            if (d + 1 > 65535) break;
            d++;
         end
      end
      exp_cnt = 16'(exp_cands.size());
   endtask

   // Compare process followed by the 3-cycle divider model.
   always @(negedge clk) begin
      if (dbus.div_start === 1'b1) begin
         tests++;
         req_d = (idx < exp_cands.size()) ? exp_cands[idx] : -1;
         if (!exp_active || int'(dbus.div_d) != req_d || dbus.div_n !== cur_p || dv_cnt != 0) begin
            fails++;
            $display("FAIL div_start: d=%0d n=%0d outstanding=%0d active=%0d, required d=%0d n=%0d",
                     dbus.div_d, dbus.div_n, dv_cnt, exp_active, req_d, cur_p);
         end
         idx++;
      end
      if (done === 1'b1) begin
         tests++;
         if (!exp_active || got_done || found !== exp_found || factor_a !== exp_a ||
             factor_b !== exp_b || cand_count !== exp_cnt || idx != exp_cands.size() || busy !== 1'b1) begin
            fails++;
            $display("FAIL result p=%0d: found=%0d a=%0d b=%0d cnt=%0d issued=%0d busy=%0d active=%0d, required found=%0d a=%0d b=%0d cnt=%0d issued=%0d",
                     cur_p, found, factor_a, factor_b, cand_count, idx, busy, exp_active,
                     exp_found, exp_a, exp_b, exp_cnt, exp_cands.size());
         end
         got_done = 1'b1;
      end
      dbus.div_done = 1'b0;
      if (dv_cnt > 0) begin
         dv_cnt--;
         if (dv_cnt == 0) begin
            dbus.div_done      = 1'b1;
            dbus.div_q         = (dv_d == 16'd0) ? 32'd0 : dv_n / {16'd0, dv_d};
            dbus.div_is_factor = (dv_d == 16'd0) ? 1'b0 : ((dv_n % {16'd0, dv_d}) == 32'd0);
         end
      end
      if (dbus.div_start === 1'b1) begin
         dv_cnt = LAT;
         dv_n   = dbus.div_n;
         dv_d   = dbus.div_d;
      end
   end

   task automatic check_zero(input string name);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || factor_a !== 16'd0 ||
          factor_b !== 32'd0 || cand_count !== 16'd0 || dbus.div_start !== 1'b0 ||
          dbus.div_n !== 32'd0 || dbus.div_d !== 16'd0) begin
         fails++;
         $display("FAIL %s: busy=%0d done=%0d found=%0d a=%0d b=%0d cnt=%0d ds=%0d dn=%0d dd=%0d, required all 0",
                  name, busy, done, found, factor_a, factor_b, cand_count,
                  dbus.div_start, dbus.div_n, dbus.div_d);
      end
   endtask

   // One request; called and returns at negedge+1.
   task automatic do_req(input logic [31:0] p, input bit mid, input bit lit,
                         input bit lf, input logic [15:0] la, input logic [31:0] lb,
                         input logic [15:0] lc);
      model(p);
      cur_p = p; idx = 0; got_done = 1'b0; exp_active = 1'b1;
      start = 1'b1; product = p;
      @(negedge clk); #1;
      start = 1'b0; product = $urandom;
      if (p < 32'd4) begin
         tests++;
         if (!got_done) begin
            fails++;
            $display("FAIL early_done p=%0d: done not seen in cycle 1, required done=1", p);
         end
      end
      if (mid) begin
         repeat (2) begin @(negedge clk); #1; end
         start = 1'b1; product = 32'd9;
         @(negedge clk); #1;
         start = 1'b0;
      end
      for (int c = 0; c < 3000 && !got_done; c++) begin
         @(negedge clk); #1;
      end
      tests++;
      if (!got_done) begin
         fails++;
         $display("FAIL timeout p=%0d: done=0 after cycle budget, required done=1", p);
      end
      @(negedge clk); #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || found !== exp_found || factor_a !== exp_a ||
          factor_b !== exp_b || cand_count !== exp_cnt) begin
         fails++;
         $display("FAIL hold p=%0d: busy=%0d done=%0d found=%0d a=%0d b=%0d cnt=%0d, required busy=0 done=0 found=%0d a=%0d b=%0d cnt=%0d",
                  p, busy, done, found, factor_a, factor_b, cand_count, exp_found, exp_a, exp_b, exp_cnt);
      end
      if (lit) begin
         tests++;
         if (found !== lf || factor_a !== la || factor_b !== lb || cand_count !== lc) begin
            fails++;
            $display("FAIL literal p=%0d: found=%0d a=%0d b=%0h cnt=%0d, required found=%0d a=%0d b=%0h cnt=%0d",
                     p, found, factor_a, factor_b, cand_count, lf, la, lb, lc);
         end
      end
      exp_active = 1'b0;
   endtask

   initial begin
      logic [31:0] rp;
      int          sel;
      reset = 1'b1; start = 1'b0; product = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;
      @(negedge clk); #1;

      do_req(32'd15, 1'b0, 1'b1, 1'b1, 16'd3, 32'd5, 16'd2);
`ifdef FACTOR_SQRT_BOUND_EN
      do_req(32'd13, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0, 16'd2);
`else
      do_req(32'd13, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0, 16'd4);
`endif
      do_req(32'd1, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0, 16'd0);
      do_req(32'd3, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0, 16'd0);
      do_req(32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 16'd2, 32'h7FFFFFFF, 16'd1);
      do_req(32'd35, 1'b1, 1'b1, 1'b1, 16'd5, 32'd7, 16'd4);
      do_req(32'd4, 1'b0, 1'b1, 1'b1, 16'd2, 32'd2, 16'd1);

      // reset while waiting on the divider; its result lands after release
      model(32'd77);
      cur_p = 32'd77; idx = 0; got_done = 1'b0; exp_active = 1'b1;
      start = 1'b1; product = 32'd77;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      reset = 1'b1; exp_active = 1'b0;
      #1;
      check_zero("reset_in_wait");
      @(negedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check_zero("stale_div_done");
      do_req(32'd21, 1'b0, 1'b1, 1'b1, 16'd3, 32'd7, 16'd2);

      for (int i = 0; i < 16; i++) begin
         sel = $urandom_range(0, 2);
         if (sel == 0) rp = 32'($urandom_range(0, 6));
         else if (sel == 1) rp = 32'($urandom_range(4, 3000));
`ifdef FACTOR_SQRT_BOUND_EN
         else rp = 32'($urandom_range(4, 4000));
`else
         else rp = $urandom;
`endif
         do_req(rp, (rp >= 32'd4) && ($urandom_range(0, 1) == 1), 1'b0, 1'b0, 16'd0, 32'd0, 16'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
